// File: rtl/hack_imem_pkg.sv
// Shared constants and FSM state type for the Hack instruction-memory loader.
package hack_imem_pkg;

  localparam int DATA_W = 16;

  localparam logic [15:0] NOP_WORD = 16'h0000;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W program store: one write port, one synchronous read port, no reset.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/hack_imem_loader.sv
// Hack CPU instruction memory: streams a program in over valid/ready, then serves fetches.
// Define IMEM_CHECKSUM_EN to build the running checksum of loaded words.
module hack_imem_loader #(
  parameter int DATA_W = hack_imem_pkg::DATA_W,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [15:0]       pc,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              reload,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow,
  output logic [DATA_W-1:0] checksum
);

  import hack_imem_pkg::*;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic [ADDR_W:0]     r_word_count;
  logic                r_cpu_reset;
  logic                r_load_ready;
  logic                r_overflow;
  logic                r_fetch_ok;
  logic                w_accept;
  logic                w_overflow_hit;
  logic                w_pc_in_range;
  logic [DATA_W-1:0]   w_rdata;

  imem_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (CLK),
    .i_we    (w_accept && !reset),
    .i_waddr (r_wr_ptr),
    .i_wdata (load_data),
    .i_raddr (pc[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  assign w_pc_in_range = (pc[15:ADDR_W] == '0) && ({1'b0, pc[ADDR_W-1:0]} < r_word_count);

  always_comb begin
    w_accept       = load_valid && r_load_ready && (r_state == ST_LOAD) && !reload;
    w_state_next   = r_state;
    w_overflow_hit = 1'b0;
    if (reload) begin
      w_state_next = ST_LOAD;
    end else if (w_accept) begin
      if (load_last) begin
        w_state_next = ST_RUN;
      end else if (r_wr_ptr == '1) begin
        w_state_next   = ST_RUN;
        w_overflow_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state      <= ST_LOAD;
      r_wr_ptr     <= '0;
      r_word_count <= '0;
      r_cpu_reset  <= 1'b1;
      r_load_ready <= 1'b0;
      r_overflow   <= 1'b0;
      r_fetch_ok   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_load_ready <= (w_state_next == ST_LOAD) && !reload;
      // cpu_reset trails the FSM by one cycle so the CPU leaves reset after RUN is entered
      r_cpu_reset  <= reload || (r_state != ST_RUN);
      r_fetch_ok   <= !reload && (r_state == ST_RUN) && w_pc_in_range;
      if (reload) begin
        r_wr_ptr     <= '0;
        r_word_count <= '0;
        r_overflow   <= 1'b0;
      end else if (w_accept) begin
        r_word_count <= r_word_count + 1'b1;
        if (r_wr_ptr != '1) begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_overflow_hit) begin
          r_overflow <= 1'b1;
        end
      end
    end
  end

  // RAM output is already registered; r_fetch_ok is the matching registered qualifier
  assign instruction = r_fetch_ok ? w_rdata : DATA_W'(NOP_WORD);
  assign cpu_reset   = r_cpu_reset;
  assign load_ready  = r_load_ready;
  assign word_count  = r_word_count;
  assign overflow    = r_overflow;

`ifdef IMEM_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  always_ff @(posedge CLK) begin
    if (reset || reload) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + load_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_hack_imem_loader.sv
// Directed self-checking bench for hack_imem_loader; fetch results go through an expected-value queue.
module tb_hack_imem_loader;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 2 ** AW;

  logic          CLK;
  logic          reset;
  logic [15:0]   pc;
  logic [DW-1:0] instruction;
  logic          cpu_reset;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          reload;
  logic [AW:0]   word_count;
  logic          overflow;
  logic [DW-1:0] checksum;

  int unsigned   n_checks = 0;
  int unsigned   n_errors = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_sum = '0;

  hack_imem_loader #(
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .pc          (pc),
    .instruction (instruction),
    .cpu_reset   (cpu_reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .reload      (reload),
    .word_count  (word_count),
    .overflow    (overflow),
    .checksum    (checksum)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] sum_model(input logic [DW-1:0] acc, input logic [DW-1:0] d);
`ifdef IMEM_CHECKSUM_EN
    return acc + d;
`else
    return acc & '0 & d;
`endif
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic last);
    int unsigned n = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    while (!load_ready && n < 20) begin
      tick();
      n++;
    end
    check("ready_wait", {31'd0, load_ready}, 32'd1);
    tick();
    exp_sum    = sum_model(exp_sum, d);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input logic [DW-1:0] exp);
    pc = a;
    exp_q.push_back(exp);
    tick();
    check("fetch", {16'd0, instruction}, {16'd0, exp_q.pop_front()});
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    tick();
    reload  = 1'b0;
    exp_sum = '0;
  endtask

  initial begin
    logic [DW-1:0] prog [4];
    prog[0] = 16'h7FFF;
    prog[1] = 16'hEC10;
    prog[2] = 16'h1000;
    prog[3] = 16'hE301;

    reset = 1'b1; pc = '0; load_valid = 1'b0; load_data = '0; load_last = 1'b0; reload = 1'b0;
    tick();
    tick();
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_checksum", 32'(checksum), 32'd0);

    // 1: basic load, cpu_reset released one cycle after RUN
    reset = 1'b0;
    check("ready_low_after_reset", 32'(load_ready), 32'd0);
    for (int i = 0; i < 4; i++) send(prog[i], i == 3);
    check("t1_word_count", 32'(word_count), 32'd4);
    check("t1_ready_off", 32'(load_ready), 32'd0);
    check("t1_cpu_reset_held", 32'(cpu_reset), 32'd1);
    check("t1_checksum", 32'(checksum), 32'(exp_sum));
    tick();
    check("t1_cpu_reset_fall", 32'(cpu_reset), 32'd0);

    // 2: fetch inside and outside the program
    for (int i = 0; i < 4; i++) fetch(16'(i), prog[i]);
    fetch(16'd4, 16'h0000);
    fetch(16'h8000, 16'h0000);
    fetch(16'd1, prog[1]);

    // 3: fill DEPTH words without last -> overflow
    pulse_reload();
    for (int i = 0; i < DEPTH; i++) send(16'hA000 + 16'(i), 1'b0);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_word_count", 32'(word_count), 32'(DEPTH));
    load_valid = 1'b1; load_data = 16'hDEAD;
    tick();
    tick();
    check("t3_extra_ready", 32'(load_ready), 32'd0);
    check("t3_extra_count", 32'(word_count), 32'(DEPTH));
    load_valid = 1'b0;
    check("t3_cpu_reset", 32'(cpu_reset), 32'd0);
    fetch(16'(DEPTH - 1), 16'hA000 + 16'(DEPTH - 1));
    fetch(16'd0, 16'hA000);
    fetch(16'(DEPTH), 16'h0000);

    // 4: reload in RUN with a concurrent load_valid
    load_valid = 1'b1; load_data = 16'hBEEF; load_last = 1'b1;
    pulse_reload();
    load_valid = 1'b0; load_last = 1'b0;
    check("t4_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t4_word_count", 32'(word_count), 32'd0);
    check("t4_overflow", 32'(overflow), 32'd0);
    check("t4_checksum", 32'(checksum), 32'd0);
    send(16'h1111, 1'b0);
    send(16'h2222, 1'b1);
    check("t4_word_count2", 32'(word_count), 32'd2);
    fetch(16'd0, 16'h1111);
    fetch(16'd1, 16'h2222);
    fetch(16'd2, 16'h0000);

    // 5: reload racing a handshake in LOAD, then reset mid-load
    pulse_reload();
    tick();
    check("t5_ready", 32'(load_ready), 32'd1);
    load_valid = 1'b1; load_data = 16'h5555;
    pulse_reload();
    load_valid = 1'b0;
    check("t5_reload_drop", 32'(word_count), 32'd0);
    send(prog[0], 1'b0);
    send(prog[1], 1'b0);
    check("t5_partial_count", 32'(word_count), 32'd2);
    fetch(16'd0, 16'h0000);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_sum = '0;
    check("t5_rst_count", 32'(word_count), 32'd0);
    check("t5_rst_instr", 32'(instruction), 32'd0);
    check("t5_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t5_rst_ready", 32'(load_ready), 32'd0);
    for (int i = 0; i < 4; i++) send(prog[3 - i], i == 3);
    check("t5_count", 32'(word_count), 32'd4);
    tick();
    check("t5_cpu_reset_fall", 32'(cpu_reset), 32'd0);
    for (int i = 0; i < 4; i++) fetch(16'(i), prog[3 - i]);

    // 6: checksum wraps modulo 2**DW; single-word program
    pulse_reload();
    send(16'h0001, 1'b0);
    send(16'hFFFF, 1'b0);
    send(16'h0003, 1'b1);
`ifdef IMEM_CHECKSUM_EN
    check("t6_checksum", 32'(checksum), 32'h0003);
`else
    check("t6_checksum", 32'(checksum), 32'h0000);
`endif
    check("t6_checksum_model", 32'(checksum), 32'(exp_sum));
    pulse_reload();
    send(16'h4242, 1'b1);
    check("t6_single_count", 32'(word_count), 32'd1);
    check("t6_single_overflow", 32'(overflow), 32'd0);
    fetch(16'd0, 16'h4242);
    fetch(16'd1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
